// File: rtl/i_arb_pkg.sv
// rtl/i_arb_pkg.sv - shared types and sizing helpers for the I-interface arbiter.
package i_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESP
  } state_e;

  function automatic int settle_cnt_w(input int settle_cycles);
    return (settle_cycles > 1) ? $clog2(settle_cycles) : 1;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i_if.sv
// rtl/i_if.sv - interface I: operands y,x in, results z=y&x, w=y^x out.
interface I;
  logic y;
  logic x;
  logic z;
  logic w;

  modport PC (output y, output x, input z, input w);
  modport DP (input y, input x, output z, output w);
endinterface

// File: rtl/i_share_arbiter_rr_pick.sv
// rtl/i_share_arbiter_rr_pick.sv - rr_pick: first set request at or after the pointer,
// as a one-hot grant plus its index.
module rr_pick
  import i_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int PW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    logic [PW-1:0] j;
    int s;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    j     = '0;
    s     = 0;
    for (int i = 0; i < N; i++) begin
      s = int'(i_ptr) + i;
      if (s >= N) s = s - N;
      j = PW'(s);
      if (!o_any && i_req[j]) begin
        o_any    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = j;
      end
    end
  end

endmodule

// File: rtl/i_share_arbiter.sv
// rtl/i_share_arbiter.sv - round-robin sharing of one I instance among N requesters.
// Optional per-requester saturating grant counters under `I_ARB_STATS_EN.
module i_share_arbiter
  import i_arb_pkg::*;
#(
  parameter int N             = 4,
  parameter int SETTLE_CYCLES = 1
`ifdef I_ARB_STATS_EN
  ,
  parameter int CNT_W         = 8
`endif
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N-1:0]     i_req_valid,
  input  logic [N-1:0]     i_req_y,
  input  logic [N-1:0]     i_req_x,
  output logic [N-1:0]     o_req_ready,
  output logic [N-1:0]     o_rsp_valid,
  output logic [N-1:0]     o_rsp_z,
  output logic [N-1:0]     o_rsp_w,
  input  logic [N-1:0]     i_rsp_ready,
  I.PC                     u_I,
`ifdef I_ARB_STATS_EN
  output logic [N*CNT_W-1:0] o_grant_cnt,
`endif
  output logic             o_busy
);

  localparam int PW = idx_w(N);
  localparam int CW = settle_cnt_w(SETTLE_CYCLES);

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] g_q, g_d;
  logic          y_q, y_d;
  logic          x_q, x_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  rsp_z_q, rsp_z_d;
  logic [N-1:0]  rsp_w_q, rsp_w_d;

  logic [N-1:0]  pick_gnt;
  logic [PW-1:0] pick_idx;
  logic          pick_any;

  rr_pick #(.N(N)) u_pick (
    .i_req (i_req_valid),
    .i_ptr (ptr_q),
    .o_gnt (pick_gnt),
    .o_idx (pick_idx),
    .o_any (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    g_d         = g_q;
    y_d         = y_q;
    x_d         = x_q;
    cnt_d       = cnt_q;
    rsp_z_d     = rsp_z_q;
    rsp_w_d     = rsp_w_q;
    o_req_ready = '0;
    o_rsp_valid = '0;
    unique case (state_q)
      IDLE: begin
        o_req_ready = pick_gnt;
        if (pick_any) begin
          g_d     = pick_idx;
          y_d     = i_req_y[pick_idx];
          x_d     = i_req_x[pick_idx];
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          rsp_z_d[g_q] = u_I.z;
          rsp_w_d[g_q] = u_I.w;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        o_rsp_valid[g_q] = 1'b1;
        if (i_rsp_ready[g_q]) begin
          state_d = IDLE;
          ptr_d   = (g_q == PW'(N - 1)) ? '0 : g_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      y_q     <= 1'b0;
      x_q     <= 1'b0;
      cnt_q   <= '0;
      rsp_z_q <= '0;
      rsp_w_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      y_q     <= y_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      rsp_z_q <= rsp_z_d;
      rsp_w_q <= rsp_w_d;
    end
  end

  // Operands stay on the shared instance after SETTLE so downstream logic sees no glitch.
  assign u_I.y   = y_q;
  assign u_I.x   = x_q;
  assign o_rsp_z = rsp_z_q;
  assign o_rsp_w = rsp_w_q;
  assign o_busy  = (state_q != IDLE);

`ifdef I_ARB_STATS_EN
  logic [N*CNT_W-1:0] gcnt_q, gcnt_d;

  always_comb begin
    gcnt_d = gcnt_q;
    for (int k = 0; k < N; k++) begin
      if ((state_q == IDLE) && pick_gnt[k] && (gcnt_q[k*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
        gcnt_d[k*CNT_W +: CNT_W] = gcnt_q[k*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) gcnt_q <= '0;
    else          gcnt_q <= gcnt_d;
  end

  assign o_grant_cnt = gcnt_q;
`endif

  for (genvar k = 0; k < N; k++) begin : g_hold
    a_hold_valid: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (i_req_valid[k] && !o_req_ready[k]) |=> i_req_valid[k]);
  end

endmodule

// File: tb/tb_i_share_arbiter.sv
// tb/tb_i_share_arbiter.sv - directed self-checking bench for i_share_arbiter (N=4, SETTLE_CYCLES=2).
module tb_i_share_arbiter;

  localparam int N = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_y = '0;
  logic [N-1:0] req_x = '0;
  logic [N-1:0] rsp_ready = '0;
  logic [N-1:0] req_ready, rsp_valid, rsp_z, rsp_w;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  I u_if ();
  assign u_if.z = u_if.y & u_if.x;
  assign u_if.w = u_if.y ^ u_if.x;

`ifdef I_ARB_STATS_EN
  logic [N*2-1:0] grant_cnt;
`endif

  i_share_arbiter #(
    .N(N),
    .SETTLE_CYCLES(S)
`ifdef I_ARB_STATS_EN
    , .CNT_W(2)
`endif
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_y     (req_y),
    .i_req_x     (req_x),
    .o_req_ready (req_ready),
    .o_rsp_valid (rsp_valid),
    .o_rsp_z     (rsp_z),
    .o_rsp_w     (rsp_w),
    .i_rsp_ready (rsp_ready),
    .u_I         (u_if),
`ifdef I_ARB_STATS_EN
    .o_grant_cnt (grant_cnt),
`endif
    .o_busy      (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
    repeat (2) tick;
    #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b exp 0000", req_ready); end
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b exp 0000", rsp_valid); end
    checks++; if (rsp_z !== 4'b0) begin errors++; $display("FAIL reset_rsp_z: got %b exp 0000", rsp_z); end
    checks++; if (rsp_w !== 4'b0) begin errors++; $display("FAIL reset_rsp_w: got %b exp 0000", rsp_w); end
    checks++; if (u_if.y !== 1'b0) begin errors++; $display("FAIL reset_if_y: got %b exp 0", u_if.y); end
    checks++; if (u_if.x !== 1'b0) begin errors++; $display("FAIL reset_if_x: got %b exp 0", u_if.x); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_single(input int k, input logic y, input logic x, input logic ez, input logic ew);
    logic [N-1:0] oh;
    oh = '0; oh[k] = 1'b1;
    req_valid = oh; req_y[k] = y; req_x[k] = x;
    #1;
    checks++; if (req_ready !== oh) begin errors++; $display("FAIL single%0d_accept: got %b exp %b", k, req_ready, oh); end
    tick;
    req_valid = '0;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single%0d_busy: got %b exp 1", k, busy); end
    checks++; if (u_if.y !== y || u_if.x !== x) begin errors++; $display("FAIL single%0d_if_c1: got y=%b x=%b exp y=%b x=%b", k, u_if.y, u_if.x, y, x); end
    tick;
    checks++; if (u_if.y !== y || u_if.x !== x) begin errors++; $display("FAIL single%0d_if_c2: got y=%b x=%b exp y=%b x=%b", k, u_if.y, u_if.x, y, x); end
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL single%0d_early_rsp: got %b exp 0000", k, rsp_valid); end
    tick;
    checks++; if (rsp_valid !== oh) begin errors++; $display("FAIL single%0d_rsp_valid: got %b exp %b", k, rsp_valid, oh); end
    checks++; if (rsp_z[k] !== ez || rsp_w[k] !== ew) begin errors++; $display("FAIL single%0d_rsp_data: got z=%b w=%b exp z=%b w=%b", k, rsp_z[k], rsp_w[k], ez, ew); end
    rsp_ready = oh;
    tick;
    rsp_ready = '0;
    #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 4'b0) begin errors++; $display("FAIL single%0d_idle: got busy=%b rsp_valid=%b exp busy=0 rsp_valid=0000", k, busy, rsp_valid); end
    checks++; if (u_if.y !== y) begin errors++; $display("FAIL single%0d_if_hold: got %b exp %b", k, u_if.y, y); end
  endtask

  task automatic test_round_robin;
    int remaining [N];
    int exp_order [5];
    logic [N-1:0] exp_z, exp_w, acc, oh;
    int n_acc, n_rsp, last, k;
    remaining = '{2, 1, 1, 1};
    exp_order = '{0, 1, 2, 3, 0};
    req_y = 4'b0101; req_x = 4'b0011;
    exp_z = 4'b0001; exp_w = 4'b0110;
    req_valid = 4'hF; rsp_ready = 4'hF;
    n_acc = 0; n_rsp = 0; last = 0;
    #1;
    for (int c = 0; c < 60 && n_rsp < 5; c++) begin
      acc = req_ready;
      if (acc != 4'b0 && n_acc < 5) begin
        oh = '0; oh[exp_order[n_acc]] = 1'b1;
        checks++; if (acc !== oh) begin errors++; $display("FAIL rr_grant%0d: got %b exp %b", n_acc, acc, oh); end
        if (n_acc > 0) begin
          checks++; if (c - last != 4) begin errors++; $display("FAIL rr_period%0d: got %0d exp 4", n_acc, c - last); end
        end
        last = c; n_acc++;
      end
      if (rsp_valid != 4'b0 && n_rsp < 5) begin
        k = exp_order[n_rsp];
        oh = '0; oh[k] = 1'b1;
        checks++; if (rsp_valid !== oh) begin errors++; $display("FAIL rr_rsp%0d_valid: got %b exp %b", n_rsp, rsp_valid, oh); end
        checks++; if (rsp_z[k] !== exp_z[k] || rsp_w[k] !== exp_w[k]) begin errors++; $display("FAIL rr_rsp%0d_data: got z=%b w=%b exp z=%b w=%b", n_rsp, rsp_z[k], rsp_w[k], exp_z[k], exp_w[k]); end
        n_rsp++;
      end
      tick;
      for (int j = 0; j < N; j++) begin
        if (acc[j]) begin
          remaining[j]--;
          if (remaining[j] == 0) req_valid[j] = 1'b0;
        end
      end
      #1;
    end
    checks++; if (n_rsp != 5) begin errors++; $display("FAIL rr_timeout: got %0d responses exp 5", n_rsp); end
    rsp_ready = '0;
    tick;
  endtask

  task automatic test_backpressure;
    req_y = 4'b0010; req_x = 4'b0110;
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_accept: got %b exp 0010", req_ready); end
    tick;
    req_valid = 4'b0100;
    tick;
    tick;
    rsp_ready = 4'b1101;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL bp_hold%0d_valid: got %b exp 0010", c, rsp_valid); end
      checks++; if (rsp_z[1] !== 1'b1 || rsp_w[1] !== 1'b0) begin errors++; $display("FAIL bp_hold%0d_data: got z=%b w=%b exp z=1 w=0", c, rsp_z[1], rsp_w[1]); end
      checks++; if (req_ready !== 4'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_hold%0d_noaccept: got ready=%b busy=%b exp ready=0000 busy=1", c, req_ready, busy); end
      tick;
    end
    rsp_ready = 4'hF;
    tick;
    rsp_ready = '0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release_idle: got %b exp 0", busy); end
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_next_grant: got %b exp 0100", req_ready); end
  endtask

  task automatic test_reset_settle;
    tick;
    req_valid = '0;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rs_settle_busy: got %b exp 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 4'b0) begin errors++; $display("FAIL rs_abort: got busy=%b rsp_valid=%b exp 0 0000", busy, rsp_valid); end
    tick;
    tick;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick;
      checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL rs_no_rsp%0d: got %b exp 0000", c, rsp_valid); end
    end
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rs_ptr_zero: got %b exp 0001", req_ready); end
    rst_n = 1'b0;
    req_valid = '0;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_reset_resp;
    req_y = 4'b0001; req_x = 4'b0001;
    req_valid = 4'b0001;
    tick;
    req_valid = '0;
    tick;
    tick;
    #1;
    checks++; if (rsp_valid !== 4'b0001 || rsp_z[0] !== 1'b1) begin errors++; $display("FAIL rr_resp_before: got valid=%b z0=%b exp 0001 1", rsp_valid, rsp_z[0]); end
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL rr_resp_drop: got %b exp 0000", rsp_valid); end
    checks++; if (rsp_z !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL rr_resp_clear: got z=%b busy=%b exp 0000 0", rsp_z, busy); end
    tick;
    rst_n = 1'b1;
    tick;
  endtask

`ifdef I_ARB_STATS_EN
  task automatic test_stats;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    rsp_ready = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      req_valid = 4'b0010;
      tick;
      req_valid = '0;
      repeat (4) tick;
      if (i == 1) begin
        checks++; if (grant_cnt !== 8'b0000_1000) begin errors++; $display("FAIL stats_two: got %b exp 00001000", grant_cnt); end
      end
    end
    rsp_ready = '0;
    checks++; if (grant_cnt !== 8'b0000_1100) begin errors++; $display("FAIL stats_sat: got %b exp 00001100", grant_cnt); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single(2, 1'b1, 1'b1, 1'b1, 1'b0);
    test_single(1, 1'b1, 1'b0, 1'b0, 1'b1);
    test_single(3, 1'b0, 1'b0, 1'b0, 1'b0);
    test_round_robin;
    test_backpressure;
    test_reset_settle;
    test_reset_resp;
`ifdef I_ARB_STATS_EN
    test_stats;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
